// File: rtl/mips32_boot_loader.sv
// Streams a boot image from a host port into processor memory, verifies an XOR
// checksum and releases the core with a one-cycle start pulse.
module mips32_boot_loader #(
    parameter int          ADDR_W = 10,
    parameter logic [15:0] MAGIC  = 16'hB007
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    input  logic [31:0]       s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_hold,
    output logic              core_start,
    output logic              busy,
    output logic              done,
    output logic              error,
    input  logic              restart
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BASE,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         count_q, count_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         acc_q, acc_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                start_q, start_d;
    logic                xfer;

    assign s_ready    = (state_q == S_IDLE) || (state_q == S_BASE) ||
                        (state_q == S_DATA) || (state_q == S_CSUM);
    assign xfer       = s_valid && s_ready;
    assign busy       = (state_q == S_BASE) || (state_q == S_DATA) || (state_q == S_CSUM);
    assign done       = (state_q == S_DONE);
    assign error      = (state_q == S_ERR);
    assign core_hold  = (state_q != S_DONE);
    assign core_start = start_q;
    assign mem_we     = we_q;
    assign mem_addr   = waddr_q;
    assign mem_wdata  = wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            addr_q  <= '0;
            acc_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            acc_q   <= acc_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            start_q <= start_d;
        end
    end

    // Write strobe and start pulse default low so they last exactly one cycle.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        addr_d  = addr_q;
        acc_d   = acc_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        start_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    if (s_data[31:16] == MAGIC) begin
                        count_d = s_data[15:0];
                        state_d = S_BASE;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_BASE: begin
                if (xfer) begin
                    addr_d  = s_data[ADDR_W-1:0];
                    acc_d   = '0;
                    state_d = (count_q != 16'd0) ? S_DATA : S_CSUM;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    we_d    = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = s_data;
                    acc_d   = acc_q ^ s_data;
                    addr_d  = addr_q + ADDR_W'(1);
                    count_d = count_q - 16'd1;
                    if (count_q == 16'd1) begin
                        state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    if (s_data == acc_q) begin
                        state_d = S_DONE;
                        start_d = 1'b1;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_DONE, S_ERR: begin
                if (restart) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mips32_boot_loader.sv
// Directed bench for mips32_boot_loader: expected memory writes are queued as
// words are sent and matched against the write port by a negedge monitor.
module tb_mips32_boot_loader;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_valid;
    logic [31:0]   s_data;
    logic          s_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          core_hold;
    logic          core_start;
    logic          busy;
    logic          done;
    logic          error;
    logic          restart;

    int checks    = 0;
    int errors    = 0;
    int wr_cnt    = 0;
    int start_cnt = 0;
    logic [AW+31:0] exp_q[$];

    logic [31:0] prog [8] = '{32'h28010078, 32'h0c631800, 32'h20220000, 32'h0c631800,
                              32'h2842002d, 32'h0c631800, 32'h24220001, 32'hfc000000};

    mips32_boot_loader #(.ADDR_W(AW), .MAGIC(16'hB007)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_hold  (core_hold),
        .core_start (core_start),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .restart    (restart)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Monitor: every write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (core_start === 1'b1) start_cnt++;
        if (mem_we === 1'b1) begin
            wr_cnt++;
            check("write_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                logic [AW+31:0] e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(e[AW+31:32]));
                check("wr_data", mem_wdata, e[31:0]);
            end
        end
    end

    task automatic send(input logic [31:0] d);
        s_valid = 1'b1;
        s_data  = d;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic send_data(input logic [AW-1:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
        send(d);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
    endtask

    initial begin
        logic [31:0]   acc;
        logic [31:0]   d;
        logic [AW-1:0] a;
        int            sc;

        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        restart = 1'b0;
        idle(2);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_core_hold", core_hold, 1);
        check("rst_core_start", core_start, 0);
        check("rst_status", {busy, done, error}, 0);
        check("rst_s_ready", s_ready, 1);
        rst_n = 1'b1;
        idle(1);

        // Eight-word program at base 0
        send(32'hB0070008);
        check("hdr_busy", busy, 1);
        send(32'h0);
        acc = '0;
        for (int i = 0; i < 8; i++) begin
            send_data(AW'(i), prog[i]);
            acc ^= prog[i];
            if (i == 0) begin
                check("lat_we", mem_we, 1);
                check("lat_addr", 32'(mem_addr), 0);
            end
        end
        check("csum_state_busy", busy, 1);
        sc = start_cnt;
        send(acc);
        check("done_flag", done, 1);
        check("done_start", core_start, 1);
        check("done_hold", core_hold, 0);
        check("done_ready", s_ready, 0);
        idle(2);
        check("start_pulses", 32'(start_cnt - sc), 1);
        check("start_low", core_start, 0);
        check("prog_queue_empty", 32'(exp_q.size()), 0);
        do_restart();
        check("restart_idle", {done, core_hold, s_ready}, 3'b011);

        // Bad header
        send(32'h12340003);
        check("badhdr_error", error, 1);
        check("badhdr_ready", s_ready, 0);
        check("badhdr_we", mem_we, 0);
        check("badhdr_hold", core_hold, 1);
        s_valid = 1'b1;
        s_data  = 32'hB0070001;
        idle(2);
        s_valid = 1'b0;
        check("err_sticky", error, 1);
        do_restart();
        check("err_restart", {error, core_hold, s_ready}, 3'b011);

        // Address wrap, with restart ignored while in BASE
        send(32'hB0070004);
        restart = 1'b1;
        idle(1);
        restart = 1'b0;
        check("restart_ignored", {busy, error}, 2'b10);
        send(32'h000003FE);
        a   = 10'h3FE;
        acc = '0;
        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            send_data(a, d);
            acc ^= d;
            a = a + 10'd1;
        end
        send(acc);
        check("wrap_done", done, 1);
        idle(1);
        check("wrap_queue_empty", 32'(exp_q.size()), 0);
        do_restart();

        // Zero-length image, good then bad checksum
        send(32'hB0070000);
        send(32'h00000078);
        check("zero_csum_busy", busy, 1);
        send(32'h0);
        check("zero_done", done, 1);
        check("zero_we", mem_we, 0);
        do_restart();
        send(32'hB0070000);
        send(32'h00000078);
        send(32'h1);
        check("zero_bad_error", error, 1);
        do_restart();

        // Gapped load aborted by reset after the third word
        send(32'hB0070005);
        send(32'h00000010);
        for (int i = 0; i < 3; i++) begin
            send_data(AW'(16 + i), 32'hC0DE0000 + 32'(i));
            if (i < 2) begin
                idle(1);
                check("gap_we", mem_we, 0);
                idle(1);
                check("gap_busy", {busy, mem_we}, 2'b10);
            end
        end
        idle(1);
        rst_n   = 1'b0;
        s_valid = 1'b1;
        s_data  = 32'h55555555;
        #1;
        check("async_rst_hold", core_hold, 1);
        check("async_rst_busy", busy, 0);
        check("async_rst_we", mem_we, 0);
        idle(2);
        s_valid = 1'b0;
        rst_n   = 1'b1;
        idle(1);
        send(32'hB0070001);
        check("fresh_hdr_busy", {busy, mem_we}, 2'b10);
        send(32'h00000020);
        send_data(10'h020, 32'hDEADBEEF);
        send(32'hDEADBEEF);
        check("fresh_done", done, 1);
        do_restart();
        idle(2);
        check("total_writes", 32'(wr_cnt), 16);
        check("final_queue_empty", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips32_boot_loader.md
MIPS32_BOOT_LOADER -- requirements
Module: mips32_boot_loader

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width of the processor memory port.
REQ-002 Parameter MAGIC, default 16'hB007, required upper half of the header word.
REQ-003 clk  input  1  single system clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 s_valid  input  1  host word valid.
REQ-006 s_data  input  32  host word.
REQ-007 s_ready  output  1  loader accepts s_data this cycle.
REQ-008 mem_we  output  1  write strobe to processor memory.
REQ-009 mem_addr  output  ADDR_W  word address of the write.
REQ-010 mem_wdata  output  32  write data.
REQ-011 core_hold  output  1  holds the processor halted (drives HALTED) while 1.
REQ-012 core_start  output  1  one-cycle pulse; processor clears PC and TAKEN_BRANCH and starts.
REQ-013 busy, done, error  output  1 each  status flags.
REQ-014 restart  input  1  returns the loader from DONE or ERR to IDLE.

Function
REQ-015 A transfer occurs on a rising edge with s_valid=1 and s_ready=1; no other edge consumes s_data.
REQ-016 States: IDLE (expect header), BASE, DATA, CSUM, DONE, ERR; s_ready=1 in IDLE, BASE, DATA and CSUM, and 0 in DONE and ERR.
REQ-017 In IDLE, a header with s_data[31:16]==MAGIC latches count=s_data[15:0] and goes to BASE; any other header goes to ERR.
REQ-018 In BASE, the transfer latches addr=s_data[ADDR_W-1:0] and clears the checksum accumulator to 0; it goes to DATA if count!=0, else to CSUM.
REQ-019 In DATA, each transfer registers mem_wdata=s_data and mem_addr=addr, asserts mem_we for exactly the following cycle, XORs s_data into the accumulator, increments addr and decrements count.
REQ-020 Write latency is one cycle: a word transferred at edge N is presented with mem_we=1 from edge N to edge N+1.
REQ-021 addr increments modulo 2^ADDR_W; after the all-ones address the next write goes to address 0.
REQ-022 The transfer of the last data word (count==1) moves to CSUM.
REQ-023 In CSUM, the transfer compares s_data with the accumulator: a match goes to DONE, a mismatch goes to ERR.
REQ-024 Words already written are never rolled back on ERR.
REQ-025 On entry to DONE, core_start=1 for exactly one cycle and core_hold falls to 0 in that same cycle.
REQ-026 core_hold=1 in every state except DONE.
REQ-027 busy=1 in BASE, DATA and CSUM; done=1 only in DONE; error=1 only in ERR.
REQ-028 restart=1 in DONE or ERR goes to IDLE on the next edge and re-asserts core_hold; restart is ignored in all other states.
REQ-029 s_valid gaps in any state stall the FSM with no state, count or address change and mem_we=0.
REQ-030 mem_we never asserts in IDLE, BASE, CSUM, DONE or ERR except in the cycle after the last DATA transfer.

Reset
REQ-031 When rst_n=0, the block immediately enters IDLE regardless of clk.
REQ-032 During reset, outputs are: mem_we=0, mem_addr=0, mem_wdata=0, core_hold=1, core_start=0, busy=0, done=0, error=0, count=0, accumulator=0.
REQ-033 Reset in the middle of DATA abandons the transfer; no further writes occur and the next accepted word is treated as a header.

Verification
REQ-034 Header 0xB0070008, base 0x00000000, eight words 0x28010078, 0x0c631800, 0x20220000, 0x0c631800, 0x2842002d, 0x0c631800, 0x24220001, 0xfc000000, then their XOR -> writes to addresses 0..7 in order, each one cycle after its transfer; then done=1 and a single core_start pulse with core_hold=0.
REQ-035 Header 0x12340003 -> error=1 and s_ready=0 on the next cycle, no mem_we; restart=1 -> IDLE with core_hold=1.
REQ-036 Header 0xB0070004, base 0x3FE, four words -> writes to mem_addr 0x3FE, 0x3FF, 0x000, 0x001.
REQ-037 Header 0xB0070000, base 0x78, checksum 0x00000000 -> DONE with zero writes; same sequence with checksum 0x00000001 -> ERR.
REQ-038 Valid load with s_valid toggling 1-0-0-1 per word and rst_n pulsed low after the third data word -> three writes only, immediate IDLE with core_hold=1, then a fresh header is accepted.
